// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Holds the PC and drives the instruction-memory address. Presents the fetched
// instruction to decode as a registered IF/ID slot, split into opcode and function code.
// Applies the controller's redirects (PCSrc, PCsrcJType, killF) and the load-use stall.
// Also owns the return register RR used by CALL/RET.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   stall         in   load-use hazard; freezes PC, IF/ID and RR
//   PCSrc         in   next-PC select: 00 PC+1, 01 branch, 10 FOR, 11 jump/RET
//   PCsrcJType    in   with PCSrc=11: 0 jumpTarget, 1 RR (RET)
//   RRSrc         in   CALL in ID; capture IDPC+1 into RR
//   killF         in   flush the instruction being fetched
//   branchTarget  in   BEQ/BNE target from ID
//   forTarget     in   FOR loop target from ID
//   jumpTarget    in   JMP/CALL target from ID
//   imem_data     in   combinational instruction-memory read data
//   imem_addr     out  current PC (word address)
//   IDInstr       out  IF/ID instruction
//   opcode        out  IDInstr[15:12]
//   functionCode  out  IDInstr[2:0]
//   IDPC          out  PC of the instruction in ID
//   IDValid       out  0 when the ID slot holds a flush bubble
//   RR            out  return register
module fetch_stage #(
    parameter int unsigned             PC_W      = 16,
    parameter int unsigned             INSTR_W   = 16,
    parameter logic [INSTR_W-1:0]      NOP_INSTR = 16'hF000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [1:0]         PCSrc,
    input  logic               PCsrcJType,
    input  logic               RRSrc,
    input  logic               killF,
    input  logic [PC_W-1:0]    branchTarget,
    input  logic [PC_W-1:0]    forTarget,
    input  logic [PC_W-1:0]    jumpTarget,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] IDInstr,
    output logic [3:0]         opcode,
    output logic [2:0]         functionCode,
    output logic [PC_W-1:0]    IDPC,
    output logic               IDValid,
    output logic [PC_W-1:0]    RR
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;
    logic [PC_W-1:0]    rr_q, rr_d;

    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    id_pc_plus1;
    logic [PC_W-1:0]    npc;

    // Both increments wrap silently modulo 2^PC_W.
    assign pc_plus1    = pc_q + PC_W'(1);
    assign id_pc_plus1 = id_pc_q + PC_W'(1);

    // Next-PC select. RET reads the current RR, so a CALL captured on an
    // earlier edge is already visible here.
    always_comb begin
        npc = pc_plus1;
        unique case (PCSrc)
            2'b00:   npc = pc_plus1;
            2'b01:   npc = branchTarget;
            2'b10:   npc = forTarget;
            2'b11:   npc = PCsrcJType ? rr_q : jumpTarget;
            default: npc = pc_plus1;
        endcase
    end

    // Next-state for PC, IF/ID and RR. Stall dominates killF and RRSrc so the
    // held instruction is re-decoded and its redirect applied exactly once.
    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        rr_d       = rr_q;

        if (!stall) begin
            pc_d = npc;
            if (killF) begin
                id_instr_d = NOP_INSTR;
                id_pc_d    = '0;
                id_valid_d = 1'b0;
            end else begin
                id_instr_d = imem_data;
                id_pc_d    = pc_q;
                id_valid_d = 1'b1;
            end
            if (RRSrc) begin
                rr_d = id_pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            rr_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            rr_q       <= rr_d;
        end
    end

    // Every output is a register or a slice of one.
    assign imem_addr    = pc_q;
    assign IDInstr      = id_instr_q;
    assign opcode       = id_instr_q[15:12];
    assign functionCode = id_instr_q[2:0];
    assign IDPC         = id_pc_q;
    assign IDValid      = id_valid_q;
    assign RR           = rr_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined processor. It holds the PC, drives the instruction-memory address, and presents the fetched instruction split into opcode and function code to the decode-stage controller. It consumes the controller's redirect signals (PCSrc, PCsrcJType, RRSrc, killF) and the hazard stall. It also owns the return register used by CALL/RET.

## Interface
Parameters:
- PC_W, default 16: PC and instruction-address width. Addressing is word-based.
- INSTR_W, default 16: instruction width.
- NOP_INSTR, default 16'hF000: instruction loaded on flush. Must equal the NOOP encoding in opcodes.v with function 3'b000.

Ports:
- clk  in  1: the single clock. Everything updates on its rising edge.
- reset  in  1: synchronous, active-high.
- stall  in  1: load-use hazard. Holds PC, IF/ID and RR.
- PCSrc  in  2: next-PC select from the controller.
- PCsrcJType  in  1: when PCSrc=11, 0 selects jumpTarget and 1 selects RR (RET).
- RRSrc  in  1: CALL is in ID. Capture the return address.
- killF  in  1: flush the instruction being fetched.
- branchTarget  in  PC_W: BEQ/BNE target computed in ID.
- forTarget  in  PC_W: FOR loop target computed in ID.
- jumpTarget  in  PC_W: JMP/CALL target computed in ID.
- imem_data  in  INSTR_W: combinational instruction-memory read data.
- imem_addr  out  PC_W: equals the PC register.
- IDInstr  out  INSTR_W: IF/ID instruction.
- opcode  out  4: IDInstr[15:12].
- functionCode  out  3: IDInstr[2:0].
- IDPC  out  PC_W: PC of the instruction in ID.
- IDValid  out  1: 0 means the ID slot holds a flush bubble.
- RR  out  PC_W: return register.

## Operation
- Next-PC selection (npc):
  - PCSrc=00 selects PC+1.
  - PCSrc=01 selects branchTarget.
  - PCSrc=10 selects forTarget.
  - PCSrc=11 selects jumpTarget when PCsrcJType=0, and the current RR when PCsrcJType=1.
- PC register update, in priority order:
  1. reset: PC←0.
  2. stall: hold.
  3. otherwise: PC←npc.
- IF/ID register update, in priority order:
  1. reset: IDInstr←NOP_INSTR, IDPC←0, IDValid←0.
  2. stall: hold all fields.
  3. killF: IDInstr←NOP_INSTR, IDPC←0, IDValid←0.
  4. otherwise: IDInstr←imem_data, IDPC←PC, IDValid←1.
- Return register:
  - reset: RR←0.
  - RRSrc=1 and stall=0: RR←IDPC+1.
  - otherwise: hold.
- Arithmetic: PC+1 and IDPC+1 are computed modulo 2^PC_W. All-ones PC wraps to 0 with no flag.
- Stall takes priority over killF and RRSrc. The stalled instruction in ID is re-decoded next cycle, so its redirect takes effect then, exactly once.
- RET in ID reads RR combinationally, so a CALL write is visible to a RET decoded one or more cycles later.
- A CALL and a RET cannot both be in ID at once. No forwarding is provided for RR.

## Timing
- Fetch-to-decode latency is 1 cycle: the instruction at address A appears on IDInstr the cycle after PC=A.
- A taken redirect (killF=1 with PCSrc≠00) costs one bubble. The next edge loads the target into PC and NOP into IF/ID.
- A stall held for N cycles freezes PC, IF/ID and RR for exactly N edges. There is no loss and no duplication.
- killF with PCSrc=00 is illegal from the controller. If it does occur, the block still flushes and advances PC+1.
- Reset mid-operation:
  - The next edge forces PC=0, the NOP bubble, and RR=0, regardless of stall or killF.
  - The first fetch is address 0 in the cycle after reset deasserts.
  - IDValid becomes 1 one cycle after that.
- All outputs are registered or direct slices of registers. imem_addr has no combinational path from the inputs.

## Test plan
- **Reset then free-run:** hold reset 2 cycles, then release with imem_data = 16'h1000+addr.
  - PC goes 0,1,2,3.
  - IDInstr goes 16'h1000, 16'h1001, …, one cycle behind.
  - IDValid=1 from the second cycle after release.
- **Taken branch:** at PC=5, assert PCSrc=01, killF=1, branchTarget=16'h0040 for one cycle.
  - Next cycle: PC=0x40, IDInstr=16'hF000, IDValid=0.
  - Following cycle: IDPC=0x40.
- **Stall 3 cycles:** at PC=8 with IDPC=7, hold stall=1 while also asserting killF=1 and PCSrc=01.
  - PC=8, IDPC=7 and RR are unchanged for all 3 cycles.
  - After release: PC=9, IDPC=8.
- **CALL/RET:** with IDPC=0x12, assert RRSrc=1, PCSrc=11, PCsrcJType=0, jumpTarget=0x80, killF=1.
  - Result: RR=0x13, PC=0x80.
  - Later, PCSrc=11 with PCsrcJType=1 gives PC=0x13.
- **FOR and wrap:**
  - PCSrc=10 with forTarget=0x03 gives PC=3.
  - With PC_W=16, PC=16'hFFFF and PCSrc=00 gives PC=0.
- **Reset mid-stall:** with stall=1 and RR=0x13, assert reset for one edge.
  - Result: PC=0, RR=0, IDInstr=16'hF000, IDValid=0.
